alu16_sequencer: RTL and testbench

- Multi-cycle controller that performs 16-bit ADD16/SUB16/INC16/DEC16 (Z80 ADD HL,rr / SBC-style / INC rr / DEC rr datapath) by sequencing the shared 8-bit ALU over 2 or 3 passes.
- Sits between the instruction-execute stage (valid/ready request/response) and the 8-bit ALU.
- Drives the ALU operand and opcode inputs; samples the ALU result and status combinationally in the same cycle.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu16_flag_calc.sv | 31 +++
 rtl/alu16_sequencer.sv | 148 ++++++++++++++
 tb/tb_alu16_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants and types for the 16-bit sequencer and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    // 8-bit ALU opcodes used by the sequencer
    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_INC = 5'b01100;
    localparam logic [4:0] ALU_DEC = 5'b01101;

    // Status flag bit positions, Z80 layout {S,Z,0,H,0,PV,N,C}
    localparam int FLAG_S  = 7;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_H  = 4;
    localparam int FLAG_PV = 2;
    localparam int FLAG_N  = 1;
    localparam int FLAG_C  = 0;

    typedef enum logic [1:0] {
        OP_ADD16 = 2'd0,
        OP_SUB16 = 2'd1,
        OP_INC16 = 2'd2,
        OP_DEC16 = 2'd3
    } seq16_op_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } seq_state_t;

endpackage

// File: rtl/alu16_flag_calc.sv
// Word-wide status flags from operands, result, direction and final carry.
// Latency: combinational.
// Backpressure: none.
module alu16_flag_calc
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] r,
    input  logic         is_sub,
    input  logic         carry,
    output logic [7:0]   flags
);

    // Half carry comes out of bit W-5 into bit W-4 (bit 12 for a 16-bit word)
    always_comb begin
        flags           = '0;
        flags[FLAG_S]   = r[W-1];
        flags[FLAG_Z]   = (r == '0);
        flags[FLAG_H]   = a[W-4] ^ b[W-4] ^ r[W-4];
        if (is_sub)
            flags[FLAG_PV] = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        else
            flags[FLAG_PV] = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        flags[FLAG_N]   = is_sub;
        flags[FLAG_C]   = carry;
    end

endmodule

// File: rtl/alu16_sequencer.sv
// 16-bit ADD/SUB/INC/DEC by sequencing the shared byte ALU: low byte, high byte, optional carry fix.
// Latency: accept edge counts as cycle 1; rsp_valid rises on cycle 3 (no fix) or 4 (fix).
// Backpressure: req_ready only in IDLE; result held in DONE until rsp_ready.
module alu16_sequencer
    import alu_pkg::*;
#(
    parameter int alu_width = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [2*alu_width-1:0] req_a,
    input  logic [2*alu_width-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2*alu_width-1:0] rsp_result,
    output logic [7:0]             rsp_flags,
    output logic [alu_width-1:0]   alu_a,
    output logic [alu_width-1:0]   alu_b,
    output logic [4:0]             alu_opcode,
    input  logic [alu_width-1:0]   alu_out,
    input  logic [7:0]             alu_status
);

    localparam int WW = 2 * alu_width;

    seq_state_t             state, state_nxt;
    logic                   is_sub;
    logic [WW-1:0]          a_q, b_q;
    logic [alu_width-1:0]   res_lo, res_hi;
    logic                   c_lo, c_hi;
    logic                   fix_carry;
    logic [WW-1:0]          fin_r;
    logic                   fin_c;
    logic [7:0]             fin_flags;
    logic                   unused_status;

    // Only the carry bit of the byte ALU status is meaningful here
    assign unused_status = ^alu_status[7:1];

    // Carry out of the high byte when the low-byte carry is propagated; computed here, not by the ALU
    assign fix_carry = is_sub ? (res_hi == '0) : (res_hi == '1);

    // Result and carry as they stand on the edge that enters DONE
    assign fin_r = {alu_out, res_lo};
    assign fin_c = (state == S_FIX) ? (c_hi | fix_carry) : alu_status[0];

    alu16_flag_calc #(.W(WW)) u_flags (
        .a      (a_q),
        .b      (b_q),
        .r      (fin_r),
        .is_sub (is_sub),
        .carry  (fin_c),
        .flags  (fin_flags)
    );

    assign rsp_valid = (state == S_DONE);

    // Next-state and ALU drive; ALU sits at zero/ADD whenever it is not in use
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = ALU_ADD;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_LO;
            end
            S_LO: begin
                alu_a      = a_q[alu_width-1:0];
                alu_b      = b_q[alu_width-1:0];
                alu_opcode = is_sub ? ALU_SUB : ALU_ADD;
                state_nxt  = S_HI;
            end
            S_HI: begin
                alu_a      = a_q[WW-1:alu_width];
                alu_b      = b_q[WW-1:alu_width];
                alu_opcode = is_sub ? ALU_SUB : ALU_ADD;
                state_nxt  = c_lo ? S_FIX : S_DONE;
            end
            S_FIX: begin
                alu_a      = res_hi;
                alu_opcode = is_sub ? ALU_DEC : ALU_INC;
                state_nxt  = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Operand latch, per-pass byte capture and response register
    always_ff @(posedge clk) begin
        if (rst) begin
            is_sub     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            res_lo     <= '0;
            res_hi     <= '0;
            c_lo       <= 1'b0;
            c_hi       <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        // INC/DEC run as ADD/SUB with B forced to one
                        is_sub <= (req_op == OP_SUB16) || (req_op == OP_DEC16);
                        a_q    <= req_a;
                        if (req_op == OP_INC16 || req_op == OP_DEC16)
                            b_q <= WW'(1);
                        else
                            b_q <= req_b;
                    end
                end
                S_LO: begin
                    res_lo <= alu_out;
                    c_lo   <= alu_status[0];
                end
                S_HI: begin
                    res_hi <= alu_out;
                    c_hi   <= alu_status[0];
                end
                S_FIX: begin
                    res_hi <= alu_out;
                end
                default: ;
            endcase
            if (state != S_DONE && state_nxt == S_DONE) begin
                rsp_result <= fin_r;
                rsp_flags  <= fin_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu16_sequencer.sv
// Directed bench for alu16_sequencer with a behavioural byte ALU on the alu_* ports.
// Latency figures count the accept edge as cycle 1.
// Inputs driven and outputs sampled on the falling edge.
module tb_alu16_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_a, req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [7:0]  rsp_flags;
    logic [7:0]  alu_a, alu_b;
    logic [4:0]  alu_opcode;
    logic [7:0]  alu_out;
    logic [7:0]  alu_status;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu16_sequencer #(.alu_width(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_out    (alu_out),
        .alu_status (alu_status)
    );

    // Behavioural 8-bit ALU: result and carry/borrow in status bit 0
    logic [8:0] alu_full;
    always_comb begin
        alu_full = '0;
        case (alu_opcode)
            ALU_ADD: alu_full = {1'b0, alu_a} + {1'b0, alu_b};
            ALU_SUB: alu_full = {1'b0, alu_a} - {1'b0, alu_b};
            ALU_INC: alu_full = {1'b0, alu_a} + 9'd1;
            ALU_DEC: alu_full = {1'b0, alu_a} - 9'd1;
            default: alu_full = '0;
        endcase
        alu_out    = alu_full[7:0];
        alu_status = {7'b0, alu_full[8]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Present a request, wait for acceptance, then scramble the request inputs
    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 2'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
    endtask

    // Call on the falling edge right after the accept edge
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic [7:0]  f;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int   lat;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;

        //            op        A        B        R        flags  lat
        vecs.push_back('{2'd0, 16'h12FF, 16'h0001, 16'h1300, 8'h00, 4});
        vecs.push_back('{2'd0, 16'hFFFF, 16'h0001, 16'h0000, 8'h51, 4});
        vecs.push_back('{2'd1, 16'h1000, 16'h0001, 16'h0FFF, 8'h12, 4});
        vecs.push_back('{2'd0, 16'h7000, 16'h1000, 16'h8000, 8'h84, 3});
        vecs.push_back('{2'd2, 16'h00FF, 16'hABCD, 16'h0100, 8'h00, 4});
        vecs.push_back('{2'd1, 16'h8000, 16'h0001, 16'h7FFF, 8'h16, 4});
        vecs.push_back('{2'd1, 16'h1234, 16'h1234, 16'h0000, 8'h42, 3});
        vecs.push_back('{2'd0, 16'h8000, 16'h8000, 16'h0000, 8'h45, 3});
        vecs.push_back('{2'd1, 16'h0100, 16'h0200, 16'hFF00, 8'h93, 3});
        vecs.push_back('{2'd3, 16'h0001, 16'h5555, 16'h0000, 8'h42, 3});
        vecs.push_back('{2'd2, 16'hFFFF, 16'h0000, 16'h0000, 8'h51, 4});
        vecs.push_back('{2'd0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 8'h91, 4});

        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_result", 32'(rsp_result), 32'd0);
        chk("rst_flags", 32'(rsp_flags), 32'd0);
        chk("rst_alu_drive", {11'd0, alu_opcode, alu_a, alu_b}, 32'd0);
        rst = 1'b0;

        // Table: rsp_ready held high, so DONE lasts one cycle
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_rsp(lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_result", i), 32'(rsp_result), 32'(vecs[i].r));
            chk($sformatf("v%0d_flags", i), 32'(rsp_flags), 32'(vecs[i].f));
            chk($sformatf("v%0d_busy", i), 32'(req_ready), 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_release", i), {30'd0, rsp_valid, req_ready}, 32'd1);
        end

        // DEC16 0x0000 with the consumer stalling; a competing request must be ignored
        rsp_ready = 1'b0;
        issue(2'd3, 16'h0000, 16'h1234);
        wait_rsp(lat);
        chk("dec_lat", 32'(lat), 32'd4);
        req_valid = 1'b1; req_op = 2'd0; req_a = 16'h0101; req_b = 16'h0101;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d", k), {rsp_valid, req_ready, 6'd0, rsp_flags, rsp_result},
                {1'b1, 1'b0, 6'd0, 8'h93, 16'hFFFF});
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("hold_release", {30'd0, rsp_valid, req_ready}, 32'd1);

        // Reset while in HI drops the transaction
        issue(2'd0, 16'h12FF, 16'h0001);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_hi_state", {30'd0, rsp_valid, req_ready}, 32'd1);
        lat = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid) lat++;
        end
        chk("rst_hi_no_rsp", 32'(lat), 32'd0);

        // Normal request after the aborted one
        issue(2'd0, 16'h0FFF, 16'h0001);
        wait_rsp(lat);
        chk("post_rst_lat", 32'(lat), 32'd4);
        chk("post_rst_result", 32'(rsp_result), 32'h1000);
        chk("post_rst_flags", 32'(rsp_flags), 32'h10);
        @(negedge clk);

        // Reset while holding a valid response in DONE
        rsp_ready = 1'b0;
        issue(2'd1, 16'h0000, 16'h0001);
        wait_rsp(lat);
        chk("done_rsp_up", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_done_state", {30'd0, rsp_valid, req_ready}, 32'd1);
        chk("rst_done_result", {rsp_flags, rsp_result}, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
